// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//
// Buffers registered ALU results for a slower consumer. Each entry holds the
// 6-bit ALU result and an invalid-operation flag. Entries drain over a
// valid/ready handshake with first-word-fall-through output. A push into an
// empty FIFO becomes visible on the following cycle, because there is no bypass.
//
// The ALU cannot stall. An input that arrives while the FIFO is full is
// silently lost. When DROP_ERR=1, inputs flagged as errors are discarded
// and counted in a saturating 8-bit counter. A discard needs no space, so it
// also happens while the FIFO is full.
//
// Optional build macro:
//   ALU_FIFO_HIWAT_EN : adds a registered almost_full output that is
//                       asserted when occupancy >= HIWAT.
//
// Parameters:
//   DEPTH    : number of entries. Must be a power of two and at least 2.
//   DROP_ERR : 1 = discard and count results that have in_err=1.
//   HIWAT    : almost-full threshold, 1..DEPTH. Used only with the macro.
//
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous active-low reset
//   in_valid    : ALU result present this cycle
//   in_data     : ALU result
//   in_err      : invalid-operation flag
//   in_ready    : FIFO can accept an entry (!full)
//   out_valid   : head entry available (!empty)
//   out_data    : head entry data; 0 while empty
//   out_err     : head entry error flag; 0 while empty
//   out_ready   : consumer accepts the head entry
//   count       : current occupancy
//   full        : count == DEPTH
//   empty       : count == 0
//   drop_cnt    : number of discarded error results, saturating at 255
//   almost_full : count >= HIWAT (only with ALU_FIFO_HIWAT_EN)
// -----------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int unsigned DEPTH    = 8,
    parameter bit          DROP_ERR = 1'b0,
    parameter int unsigned HIWAT    = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [5:0]               in_data,
    input  logic                     in_err,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [5:0]               out_data,
    output logic                     out_err,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [7:0]               drop_cnt
`ifdef ALU_FIFO_HIWAT_EN
    ,
    output logic                     almost_full
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic       err;
        logic [5:0] data;
    } entry_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    entry_t     mem [DEPTH];

    ptr_t       wr_ptr_q,   wr_ptr_d;
    ptr_t       rd_ptr_q,   rd_ptr_d;
    cnt_t       count_q,    count_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;
`ifdef ALU_FIFO_HIWAT_EN
    logic       almost_full_q, almost_full_d;
`endif

    // -------------------------------------------------------------------------
    // Status, derived only from registered occupancy. This keeps in_ready
    // free of any combinational path from out_ready.
    // -------------------------------------------------------------------------
    logic full_w;
    logic empty_w;

    assign full_w  = (count_q == cnt_t'(DEPTH));
    assign empty_w = (count_q == '0);

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic drop;
    logic push;
    logic pop;

    assign drop = in_valid && in_err && DROP_ERR;
    assign push = in_valid && !full_w && !drop;
    assign pop  = out_ready && !empty_w;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch. This
        // prevents a latch on paths that do not assign it.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;

        // Power-of-two depth makes the natural pointer overflow the wrap.
        if (push) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase

        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

`ifdef ALU_FIFO_HIWAT_EN
    // Evaluated on the post-update occupancy, so the flag registers together
    // with count.
    always_comb begin
        almost_full_d = (count_d >= cnt_t'(HIWAT));
    end
`else
    // HIWAT has no function in this build.
    logic cfg_unused;
    assign cfg_unused = (HIWAT != 0);
`endif

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so all flops
    // update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            drop_cnt_q    <= '0;
`ifdef ALU_FIFO_HIWAT_EN
            almost_full_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            drop_cnt_q    <= drop_cnt_d;
`ifdef ALU_FIFO_HIWAT_EN
            almost_full_q <= almost_full_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // NOTE: the array is deliberately not reset. count_q decides which
    // entries are valid, and the read port masks stale contents while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= '{err: in_err, data: in_data};
        end
    end

    // -------------------------------------------------------------------------
    // First-word-fall-through read port
    // -------------------------------------------------------------------------
    entry_t head;

    always_comb begin
        head = '0;
        if (!empty_w) begin
            head = mem[rd_ptr_q];
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = !full_w;
    assign out_valid = !empty_w;
    assign out_data  = head.data;
    assign out_err   = head.err;
    assign count     = count_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign drop_cnt  = drop_cnt_q;
`ifdef ALU_FIFO_HIWAT_EN
    assign almost_full = almost_full_q;
`endif

endmodule
